memory_unit: RTL and testbench

- Memory-side responder to the pipelined core's instruction-fetch and data-access ports.
- Serialises both ports onto one single-port, ack-handshaked memory bus.
- Returns the fetched instruction and the load data to the core.
- Drives mem_busy, which freezes the core's IF/ID/EX pipeline registers and PC until both accesses of the current cycle are served.

---
 rtl/memory_unit_if.sv | 33 +++
 rtl/memory_unit.sv | 73 +++++++
 tb/tb_memory_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/memory_unit_if.sv
// memory_unit_if: core-side fetch/data ports and single-port memory bus bundled for memory_unit
//   master: memory_unit's view. It takes core requests and bus responses, and drives results, mem_busy and bus requests.
//   slave : the environment's view (core plus memory), with every direction reversed.
interface memory_unit_if #(parameter int DATA_SIZE = 32);
  logic [DATA_SIZE-1:0]   inst_mem_addr;
  logic                   inst_req;
  logic [31:0]            inst;
  logic [DATA_SIZE-1:0]   data_mem_addr;
  logic                   mem_rd_en;
  logic                   mem_wr_en;
  logic [DATA_SIZE/8-1:0] mem_byte_en;
  logic [DATA_SIZE-1:0]   wr_data;
  logic [DATA_SIZE-1:0]   rd_data;
  logic                   mem_busy;
  logic                   bus_cyc;
  logic                   bus_stb;
  logic                   bus_we;
  logic [DATA_SIZE-1:0]   bus_addr;
  logic [DATA_SIZE/8-1:0] bus_sel;
  logic [DATA_SIZE-1:0]   bus_wr_data;
  logic [DATA_SIZE-1:0]   bus_rd_data;
  logic                   bus_ack;
  modport master(
    input  inst_mem_addr, inst_req, data_mem_addr, mem_rd_en, mem_wr_en, mem_byte_en, wr_data,
           bus_rd_data, bus_ack,
    output inst, rd_data, mem_busy, bus_cyc, bus_stb, bus_we, bus_addr, bus_sel, bus_wr_data
  );
  modport slave(
    output inst_mem_addr, inst_req, data_mem_addr, mem_rd_en, mem_wr_en, mem_byte_en, wr_data,
           bus_rd_data, bus_ack,
    input  inst, rd_data, mem_busy, bus_cyc, bus_stb, bus_we, bus_addr, bus_sel, bus_wr_data
  );
endinterface

// File: rtl/memory_unit.sv
// memory_unit: serialises core data access then instruction fetch onto one ack-handshaked memory bus
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   mu (master)  : core fetch/data requests in; inst, rd_data and mem_busy out; bus requests out; bus responses in
module memory_unit #(
  parameter int DATA_SIZE = 32
) (
  input logic          clock,
  input logic          reset,
  memory_unit_if.master mu
);
  localparam int BE = DATA_SIZE / 8;
  typedef enum logic [1:0] {IDLE, DATA, INST, DONE} state_t;
  state_t               state, state_nx;
  logic [DATA_SIZE-1:0] i_addr, d_addr, w_data, rd_q;
  logic [BE-1:0]        b_en;
  logic                 l_we, l_inst, l_data, data_req, req;
  logic [31:0]          inst_q;
  assign data_req = mu.mem_rd_en | mu.mem_wr_en;
  assign req      = data_req | mu.inst_req;
  assign mu.inst    = inst_q;
  assign mu.rd_data = rd_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = data_req ? DATA : mu.inst_req ? INST : IDLE;
      DATA:    state_nx = mu.bus_ack ? (l_inst ? INST : DONE) : DATA;
      INST:    state_nx = mu.bus_ack ? DONE : INST;
      default: state_nx = IDLE;
    endcase
  end
  // Bus side is driven purely from state and the latched request copy, so
  // the core may change its inputs freely once a round has started.
  always_comb begin
    mu.bus_cyc     = state == DATA || state == INST;
    mu.bus_stb     = state == DATA || state == INST;
    mu.bus_we      = state == DATA && l_we;
    mu.bus_addr    = state == DATA ? d_addr : state == INST ? i_addr : '0;
    mu.bus_sel     = state == DATA ? b_en : state == INST ? {BE{1'b1}} : '0;
    mu.bus_wr_data = state == DATA ? w_data : '0;
    mu.mem_busy    = state == IDLE ? req : state != DONE;
  end
  // Both enables high counts as a store.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      i_addr <= '0;
      d_addr <= '0;
      w_data <= '0;
      b_en   <= '0;
      l_we   <= 1'b0;
      l_inst <= 1'b0;
      l_data <= 1'b0;
    end else if (state == IDLE && req) begin
      i_addr <= mu.inst_mem_addr;
      d_addr <= mu.data_mem_addr;
      w_data <= mu.wr_data;
      b_en   <= mu.mem_byte_en;
      l_we   <= mu.mem_wr_en;
      l_inst <= mu.inst_req;
      l_data <= data_req;
    end
  // Acks outside DATA/INST are ignored; stores never touch rd_data.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      inst_q <= '0;
      rd_q   <= '0;
    end else begin
      if (state == DATA && mu.bus_ack && l_data && !l_we) rd_q <= mu.bus_rd_data;
      if (state == INST && mu.bus_ack) inst_q <= mu.bus_rd_data[31:0];
    end
endmodule

// File: tb/tb_memory_unit.sv
// tb_memory_unit: scoreboard bench for memory_unit with a wait-state bus responder and decoupled monitor
module tb_memory_unit;
  logic clock = 0, reset = 1;
  always #5 clock = ~clock;
  memory_unit_if #(.DATA_SIZE(32)) mu();
  memory_unit #(.DATA_SIZE(32)) dut(.clock(clock), .reset(reset), .mu(mu.master));
  typedef struct {logic we; logic [31:0] addr; logic [3:0] sel; logic [31:0] wd; bit chk_wd;} bus_t;
  typedef struct {logic [31:0] inst; logic [31:0] rd;} res_t;
  bus_t bus_q[$];
  res_t res_q[$];
  int checks = 0, errors = 0;
  logic [31:0] m_inst = 0, m_rd = 0;
  bit manual = 1, spur = 0, in_acc = 0, prev_stb = 0;
  int cnt = 0, wd_n = 0, wi_n = 0;
  logic [31:0] cur_ia = 0, cur_da = 0, dword = 0, iword = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Bus responder: acks after the configured wait states, returning the word for the addressed access.
  always @(posedge clock) begin
    #1;
    if (!manual) begin
      if (!mu.bus_stb) begin
        in_acc = 0; cnt = 0;
        mu.bus_ack = spur;
        mu.bus_rd_data = spur ? 32'hFFFF_FFFF : 32'h0;
      end else begin
        if (mu.bus_ack || !in_acc) cnt = 0; else cnt++;
        in_acc = 1;
        mu.bus_rd_data = (mu.bus_addr == cur_ia) ? iword : dword;
        mu.bus_ack = (cnt == ((mu.bus_addr == cur_ia) ? wi_n : wd_n));
      end
    end
  end

  // Monitor: compares every accepted bus transfer and the results presented when the round ends.
  always @(negedge clock) begin
    if (!reset && mu.bus_stb && mu.bus_ack) begin
      if (bus_q.size() == 0) chk("bus_unexpected", 1, 0);
      else begin
        bus_t e;
        e = bus_q.pop_front();
        chk("bus_we", {31'b0, mu.bus_we}, {31'b0, e.we});
        chk("bus_addr", mu.bus_addr, e.addr);
        chk("bus_sel", {28'b0, mu.bus_sel}, {28'b0, e.sel});
        chk("bus_cyc", {31'b0, mu.bus_cyc}, 1);
        if (e.chk_wd) chk("bus_wr_data", mu.bus_wr_data, e.wd);
      end
    end
    if (!reset && prev_stb && !mu.bus_stb) begin
      if (res_q.size() == 0) chk("res_unexpected", 1, 0);
      else begin
        res_t r;
        r = res_q.pop_front();
        chk("inst", mu.inst, r.inst);
        chk("rd_data", mu.rd_data, r.rd);
      end
    end
    prev_stb = mu.bus_stb;
  end

  task automatic run(input string nm, input bit ir, input logic [31:0] ia, input bit rd, input bit wr,
                     input logic [31:0] da, input logic [3:0] be, input logic [31:0] wdat,
                     input logic [31:0] dw, input logic [31:0] iw, input int wdn, input int win,
                     input bit pert, input int exp_busy);
    int busy;
    cur_ia = ia; cur_da = da; dword = dw; iword = iw; wd_n = wdn; wi_n = win; manual = 0;
    if (rd || wr) bus_q.push_back('{wr, da, be, wdat, 1'b1});
    if (ir) bus_q.push_back('{1'b0, ia, 4'hF, 32'h0, 1'b0});
    if (rd && !wr) m_rd = dw;
    if (ir) m_inst = iw;
    res_q.push_back('{m_inst, m_rd});
    @(posedge clock); #2;
    mu.inst_req = ir; mu.inst_mem_addr = ia; mu.mem_rd_en = rd; mu.mem_wr_en = wr;
    mu.data_mem_addr = da; mu.mem_byte_en = be; mu.wr_data = wdat;
    @(negedge clock);
    chk({nm, " busy_idle"}, {31'b0, mu.mem_busy}, 1);
    @(posedge clock); #2;
    mu.inst_req = 0; mu.mem_rd_en = 0; mu.mem_wr_en = 0;
    if (pert) begin
      mu.inst_mem_addr = 32'h200; mu.data_mem_addr = 32'h3000; mu.mem_byte_en = 4'h5; mu.wr_data = 32'h12345678;
    end
    busy = 1;
    forever begin
      @(negedge clock);
      if (!mu.mem_busy) break;
      busy++;
      if (pert && mu.bus_stb) chk({nm, " addr_hold"}, mu.bus_addr, ia);
      if (busy > 60) begin
        checks++; errors++;
        $display("FAIL %s timeout actual=busy required=idle", nm);
        break;
      end
    end
    chk({nm, " busy_cycles"}, busy, exp_busy);
  endtask

  initial begin
    mu.inst_req = 0; mu.inst_mem_addr = 0; mu.mem_rd_en = 0; mu.mem_wr_en = 0;
    mu.data_mem_addr = 0; mu.mem_byte_en = 0; mu.wr_data = 0; mu.bus_ack = 0; mu.bus_rd_data = 0;
    #3;
    chk("rst bus_stb", {31'b0, mu.bus_stb}, 0);
    chk("rst bus_cyc", {31'b0, mu.bus_cyc}, 0);
    chk("rst bus_addr", mu.bus_addr, 0);
    chk("rst mem_busy", {31'b0, mu.mem_busy}, 0);
    chk("rst inst", mu.inst, 0);
    chk("rst rd_data", mu.rd_data, 0);
    @(posedge clock); #2 reset = 0;
    run("fetch", 1, 32'h100, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h00500093, 0, 0, 0, 2);
    run("load_fetch", 1, 32'h104, 1, 0, 32'h2000, 4'hF, 32'h0, 32'hCAFEF00D, 32'h00108093, 2, 2, 0, 7);
    run("store_fetch", 1, 32'h108, 0, 1, 32'h2004, 4'h3, 32'hDEADBEEF, 32'h11111111, 32'h00208113, 0, 0, 0, 3);
    run("rdwr_store", 0, 32'h0, 1, 1, 32'h2008, 4'hF, 32'h0BADC0DE, 32'h22222222, 32'h0, 1, 0, 0, 3);
    run("load_only", 0, 32'h0, 1, 0, 32'h2010, 4'hF, 32'h0, 32'h55AA55AA, 32'h0, 0, 0, 0, 2);
    spur = 1;
    repeat (3) @(negedge clock);
    chk("spur_idle inst", mu.inst, m_inst);
    chk("spur_idle rd_data", mu.rd_data, m_rd);
    chk("spur_idle bus_stb", {31'b0, mu.bus_stb}, 0);
    chk("spur_idle mem_busy", {31'b0, mu.mem_busy}, 0);
    run("spur_fetch", 1, 32'h10C, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h00A00113, 0, 1, 0, 3);
    repeat (3) @(negedge clock);
    chk("spur_done inst", mu.inst, 32'h00A00113);
    chk("spur_done rd_data", mu.rd_data, 32'h55AA55AA);
    chk("spur_done bus_stb", {31'b0, mu.bus_stb}, 0);
    spur = 0;
    run("addr_change", 1, 32'h108, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h00300193, 0, 3, 1, 5);
    manual = 1; mu.bus_ack = 0; mu.bus_rd_data = 0;
    @(posedge clock); #2;
    mu.mem_rd_en = 1; mu.data_mem_addr = 32'h2020; mu.mem_byte_en = 4'hF;
    @(posedge clock); #2;
    mu.mem_rd_en = 0;
    @(negedge clock);
    chk("mid_data bus_stb", {31'b0, mu.bus_stb}, 1);
    @(posedge clock); #3 reset = 1;
    #1;
    chk("async_rst bus_stb", {31'b0, mu.bus_stb}, 0);
    chk("async_rst bus_cyc", {31'b0, mu.bus_cyc}, 0);
    chk("async_rst mem_busy", {31'b0, mu.mem_busy}, 0);
    chk("async_rst inst", mu.inst, 0);
    chk("async_rst rd_data", mu.rd_data, 0);
    mu.bus_ack = 1; mu.bus_rd_data = 32'hFFFF_FFFF;
    repeat (2) @(posedge clock);
    #2 reset = 0;
    repeat (3) @(negedge clock);
    chk("post_rst rd_data", mu.rd_data, 0);
    chk("post_rst inst", mu.inst, 0);
    chk("post_rst bus_stb", {31'b0, mu.bus_stb}, 0);
    mu.bus_ack = 0; mu.bus_rd_data = 0;
    repeat (2) @(negedge clock);
    chk("bus_q drained", bus_q.size(), 0);
    chk("res_q drained", res_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
